regfile_reader: RTL

- Read-side counterpart of the one-hot write-enable path: a 16-entry register bank written through the 16-bit one-hot enable vector from the 4-to-16 decoder, plus the read logic.
- Provides two registered random-read ports and a sequential scan engine that streams every register out over a valid/ready handshake.
- Sits between the write-enable decoder and the datapath and debug consumers of the factorization core.

---
 rtl/regfile_reader_pkg.sv | 13 +
 rtl/regfile_reader_onehot_check.sv | 30 +++
 rtl/regfile_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/regfile_reader_pkg.sv
// Shared constants and scan-engine state encoding for the register bank reader.
package regfile_reader_pkg;

    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StShow = 2'd1,
        StFin  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/regfile_reader_onehot_check.sv
// Classifies the write-enable vector and encodes a valid one-hot vector to its index.
module regfile_reader_onehot_check
    import regfile_reader_pkg::*;
(
    input  logic [NREG-1:0] i_en,
    output logic            o_onehot,
    output logic            o_zero,
    output logic            o_multi,
    output logic [AW-1:0]   o_idx
);

    logic [NREG-1:0] w_low_cleared;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_low_cleared = i_en & (i_en - NREG'(1));
    assign o_zero        = (i_en == '0);
    assign o_multi       = (w_low_cleared != '0);
    assign o_onehot      = !o_zero && !o_multi;

    // OR of set-bit positions; only meaningful when the vector is one-hot.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_en[i]) begin
                o_idx = o_idx | AW'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_reader.sv
// 16-entry register bank with one-hot writes, two registered read ports and a
// valid/ready scan engine that streams every register out in address order.
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREG-1:0] EN,
    input  logic [DW-1:0]   WD,
    input  logic [AW-1:0]   RA1,
    input  logic [AW-1:0]   RA2,
    output logic [DW-1:0]   RD1,
    output logic [DW-1:0]   RD2,
    output logic            EnErr,
    input  logic            ScanStart,
    output logic            ScanBusy,
    output logic            ScanValid,
    input  logic            ScanReady,
    output logic [AW-1:0]   ScanAdd,
    output logic [DW-1:0]   ScanData,
    output logic            ScanDone
);

    logic [DW-1:0] r_regs [NREG];
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;
    logic          r_en_err;
    scan_state_e   r_state;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_scan_data;

    logic          w_wr_onehot;
    logic          w_wr_zero;
    logic          w_wr_multi;
    logic [AW-1:0] w_wr_idx;
    logic [DW-1:0] w_rd1_d;
    logic [DW-1:0] w_rd2_d;
    logic [AW-1:0] w_ld_addr;
    logic [DW-1:0] w_ld_data;
    scan_state_e   w_state_d;
    logic [AW-1:0] w_idx_d;
    logic [DW-1:0] w_data_d;

    regfile_reader_onehot_check u_onehot_check (
        .i_en     (EN),
        .o_onehot (w_wr_onehot),
        .o_zero   (w_wr_zero),
        .o_multi  (w_wr_multi),
        .o_idx    (w_wr_idx)
    );

    // Write-first bypass: a same-cycle valid write to the read address wins.
    assign w_rd1_d   = (w_wr_onehot && (w_wr_idx == RA1)) ? WD : r_regs[RA1];
    assign w_rd2_d   = (w_wr_onehot && (w_wr_idx == RA2)) ? WD : r_regs[RA2];

    // Address the scan engine would load next: 0 on start, idx+1 on an accepted beat.
    assign w_ld_addr = (r_state == StIdle) ? '0 : r_idx + AW'(1);
    assign w_ld_data = (w_wr_onehot && (w_wr_idx == w_ld_addr)) ? WD : r_regs[w_ld_addr];

    // Register bank: only an exactly one-hot enable writes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_onehot) begin
            r_regs[w_wr_idx] <= WD;
        end
    end

    // Read ports and the enable-error pulse, all one cycle behind their inputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_en_err <= 1'b0;
        end else begin
            r_rd1    <= w_rd1_d;
            r_rd2    <= w_rd2_d;
            r_en_err <= w_wr_multi;
        end
    end

    // Scan engine state, beat index and snapshot of the beat data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_scan_data <= '0;
        end else begin
            r_state     <= w_state_d;
            r_idx       <= w_idx_d;
            r_scan_data <= w_data_d;
        end
    end

    // Scan next-state: data is only reloaded when a new beat begins, so a stalled
    // beat stays a stable snapshot even if its register is rewritten.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_data_d  = r_scan_data;
        unique case (r_state)
            StIdle: begin
                if (ScanStart) begin
                    w_state_d = StShow;
                    w_idx_d   = '0;
                    w_data_d  = w_ld_data;
                end
            end
            StShow: begin
                if (ScanReady) begin
                    if (r_idx == AW'(NREG - 1)) begin
                        w_state_d = StFin;
                    end else begin
                        w_idx_d  = w_ld_addr;
                        w_data_d = w_ld_data;
                    end
                end
            end
            StFin: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign RD1       = r_rd1;
    assign RD2       = r_rd2;
    assign EnErr     = r_en_err;
    assign ScanBusy  = (r_state != StIdle);
    assign ScanValid = (r_state == StShow);
    assign ScanDone  = (r_state == StFin);
    assign ScanAdd   = r_idx;
    assign ScanData  = r_scan_data;

    logic w_unused;
    assign w_unused = w_wr_zero;

endmodule
